// File: rtl/majority_vote_controller_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// majority_vote_controller_if : voter-side and result-side signals of one round
// Rev 1.0
// ---------------------------------------------------------------------------
interface majority_vote_controller_if #(
   parameter int N = 4
);
   localparam int CW = $clog2(N + 1);

   logic          i_start;
   logic [N-1:0]  i_vote_valid;
   logic [N-1:0]  i_vote_val;
   logic [N-1:0]  o_vote_ack;
   logic          o_busy;
   logic          o_done;
   logic          o_out;
   logic          o_equal;
   logic [CW-1:0] o_ones_cnt;
   logic [N-1:0]  o_voted_mask;
   logic          o_timed_out;

   modport master (
      output i_start, i_vote_valid, i_vote_val,
      input  o_vote_ack, o_busy, o_done, o_out, o_equal, o_ones_cnt, o_voted_mask, o_timed_out
   );

   modport slave (
      input  i_start, i_vote_valid, i_vote_val,
      output o_vote_ack, o_busy, o_done, o_out, o_equal, o_ones_cnt, o_voted_mask, o_timed_out
   );
endinterface
`default_nettype wire

// File: rtl/majority_vote_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// majority_vote_controller : collects one vote per voter, registers majority.
// Optional forced close after TO_CYC collect cycles when VOTE_TIMEOUT_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
module majority_vote_controller #(
   parameter int N      = 4,
   parameter int TO_CYC = 16
) (
   input  wire logic                  clk,
   input  wire logic                  rst_n,
   majority_vote_controller_if.slave  bus
);
   localparam int CW = $clog2(N + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DECIDE  = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_votes;
   logic [N-1:0]  r_mask;
   logic [N-1:0]  r_ack;
   logic          r_done;
   logic          r_out;
   logic          r_equal;
   logic          r_timed_out;
   logic [CW-1:0] r_ones;
   logic [N-1:0]  w_acc;
   logic [N-1:0]  w_mask_nxt;
   logic          w_full;
   logic          w_to_hit;
   logic [CW-1:0] w_ones;
   logic [CW-1:0] w_voted;
   logic [CW-1:0] w_zeros;

   function automatic logic [CW-1:0] popcnt(input logic [N-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + CW'(v[i]);
      return c;
   endfunction

   assign w_acc      = (r_state == S_COLLECT) ? (bus.i_vote_valid & ~r_mask) : '0;
   assign w_mask_nxt = r_mask | w_acc;
   assign w_full     = &w_mask_nxt;

   // Absent voters are masked out, so a timed-out round only weighs cast votes
   assign w_ones  = popcnt(r_votes & r_mask);
   assign w_voted = popcnt(r_mask);
   assign w_zeros = w_voted - w_ones;

`ifdef VOTE_TIMEOUT_EN
   localparam int c_TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
   logic [c_TW-1:0] r_to_cnt;

   assign w_to_hit = (r_state == S_COLLECT) && (r_to_cnt == c_TW'(TO_CYC - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_to_cnt <= '0;
      end else if (r_state == S_IDLE && bus.i_start) begin
         r_to_cnt <= '0;
      end else if (r_state == S_COLLECT) begin
         r_to_cnt <= r_to_cnt + c_TW'(1);
      end
   end
`else
   // No forced close: TO_CYC only sanity-gates a constant-false hit
   assign w_to_hit = 1'b0 & (TO_CYC > 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (bus.i_start) w_state_nxt = S_COLLECT;
         S_COLLECT: if (w_full || w_to_hit) w_state_nxt = S_DECIDE;
         S_DECIDE:  w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_votes     <= '0;
         r_mask      <= '0;
         r_ack       <= '0;
         r_done      <= 1'b0;
         r_out       <= 1'b0;
         r_equal     <= 1'b0;
         r_ones      <= '0;
         r_timed_out <= 1'b0;
      end else begin
         r_ack  <= w_acc;
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_votes     <= '0;
                  r_mask      <= '0;
                  r_timed_out <= 1'b0;
               end
            end
            S_COLLECT: begin
               r_votes <= (r_votes & ~w_acc) | (bus.i_vote_val & w_acc);
               r_mask  <= w_mask_nxt;
               if (w_to_hit && !w_full) r_timed_out <= 1'b1;
            end
            S_DECIDE: begin
               r_ones  <= w_ones;
               r_equal <= (w_ones == w_zeros);
               r_out   <= (w_ones > w_zeros);
               r_done  <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.o_vote_ack   = r_ack;
   assign bus.o_busy       = (r_state != S_IDLE);
   assign bus.o_done       = r_done;
   assign bus.o_out        = r_out;
   assign bus.o_equal      = r_equal;
   assign bus.o_ones_cnt   = r_ones;
   assign bus.o_voted_mask = r_mask;
   assign bus.o_timed_out  = r_timed_out;
endmodule
`default_nettype wire

// File: tb/tb_majority_vote_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_majority_vote_controller : randomized rounds against a round-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_majority_vote_controller;
   localparam int N      = 4;
   localparam int TO_CYC = 16;
   localparam int CW     = $clog2(N + 1);

   typedef struct packed {
      logic          out;
      logic          eq;
      logic [CW-1:0] ones;
      logic [N-1:0]  mask;
      logic          to;
   } res_t;

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   majority_vote_controller_if #(.N(N)) bus ();

   majority_vote_controller #(.N(N), .TO_CYC(TO_CYC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Round-level model state
   int           m_phase;
   int           m_cnt;
   logic [N-1:0] m_mask;
   logic [N-1:0] m_votes;
   logic         m_to;
   res_t         m_last;
   res_t         exp_q[$];

   logic [N-1:0] nxt_ack, vis_ack, nxt_mask, vis_mask;
   logic         nxt_busy, vis_busy, nxt_to, vis_to;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vis_ack <= '0; vis_mask <= '0; vis_busy <= 1'b0; vis_to <= 1'b0;
      end else begin
         vis_ack <= nxt_ack; vis_mask <= nxt_mask; vis_busy <= nxt_busy; vis_to <= nxt_to;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pop on done, continuous per-cycle checks otherwise
   always @(negedge clk) begin
      if (rst_n) begin
         chk("vote_ack", 32'(bus.o_vote_ack), 32'(vis_ack));
         chk("busy", 32'(bus.o_busy), 32'(vis_busy));
         chk("voted_mask", 32'(bus.o_voted_mask), 32'(vis_mask));
         chk("timed_out", 32'(bus.o_timed_out), 32'(vis_to));
         if (bus.o_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               res_t e;
               e = exp_q.pop_front();
               chk("done_out", 32'(bus.o_out), 32'(e.out));
               chk("done_equal", 32'(bus.o_equal), 32'(e.eq));
               chk("done_ones", 32'(bus.o_ones_cnt), 32'(e.ones));
               chk("done_mask", 32'(bus.o_voted_mask), 32'(e.mask));
               chk("done_timed_out", 32'(bus.o_timed_out), 32'(e.to));
               m_last = e;
            end
         end else begin
            chk("hold_out", 32'(bus.o_out), 32'(m_last.out));
            chk("hold_equal", 32'(bus.o_equal), 32'(m_last.eq));
            chk("hold_ones", 32'(bus.o_ones_cnt), 32'(m_last.ones));
         end
      end
   end

   // One clock of stimulus; the model predicts what becomes visible after the edge
   task automatic step(input logic s, input logic [N-1:0] v, input logic [N-1:0] d);
      logic [N-1:0] acc;
      int           ones, voted;
      bit           hit;
      bus.i_start = s; bus.i_vote_valid = v; bus.i_vote_val = d;
      nxt_ack = '0;
      case (m_phase)
         0: if (s) begin
               m_mask = '0; m_votes = '0; m_to = 1'b0; m_cnt = 0; m_phase = 1;
            end
         1: begin
               acc = v & ~m_mask;
               nxt_ack = acc;
               for (int i = 0; i < N; i++) if (acc[i]) m_votes[i] = d[i];
               m_mask = m_mask | acc;
`ifdef VOTE_TIMEOUT_EN
               hit = (m_cnt == TO_CYC - 1);
`else
               hit = 1'b0;
`endif
               m_cnt++;
               if (&m_mask) m_phase = 2;
               else if (hit) begin m_phase = 2; m_to = 1'b1; end
            end
         default: begin
               ones = 0; voted = 0;
               for (int i = 0; i < N; i++) begin
                  if (m_mask[i]) begin
                     voted++;
                     if (m_votes[i]) ones++;
                  end
               end
               exp_q.push_back('{out: (ones > voted - ones), eq: (ones == voted - ones),
                                 ones: CW'(ones), mask: m_mask, to: m_to});
               m_phase = 0;
            end
      endcase
      nxt_busy = (m_phase != 0); nxt_mask = m_mask; nxt_to = m_to;
      @(posedge clk); #1;
      bus.i_start = 1'b0; bus.i_vote_valid = '0; bus.i_vote_val = '0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0);
   endtask

   task automatic finish_round(input string name);
      int c;
      c = 0;
      while (m_phase != 0 && c < 60) begin step(1'b0, '0, '0); c++; end
      chk({name, "_closed"}, 32'(m_phase), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_ack", 32'(bus.o_vote_ack), 32'd0);
      chk("rst_done", 32'(bus.o_done), 32'd0);
      chk("rst_out", 32'(bus.o_out), 32'd0);
      chk("rst_equal", 32'(bus.o_equal), 32'd0);
      chk("rst_ones", 32'(bus.o_ones_cnt), 32'd0);
      chk("rst_mask", 32'(bus.o_voted_mask), 32'd0);
      chk("rst_timed_out", 32'(bus.o_timed_out), 32'd0);
      m_phase = 0; m_cnt = 0; m_mask = '0; m_votes = '0; m_to = 1'b0; m_last = '0;
      nxt_ack = '0; nxt_mask = '0; nxt_busy = 1'b0; nxt_to = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      tests = 0; fails = 0;
      bus.i_start = 1'b0; bus.i_vote_valid = '0; bus.i_vote_val = '0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_reset();
      idle(2);

      // All voters in one cycle: 1,1,0,1
      step(1'b1, '0, '0);
      step(1'b0, 4'b1111, 4'b1011);
      finish_round("all_same_cycle");
      idle(2);

      // Staggered 1,0,1,0
      step(1'b1, '0, '0);
      for (int i = 0; i < N; i++) step(1'b0, 4'(1 << i), (i % 2 == 0) ? 4'(1 << i) : 4'b0000);
      finish_round("staggered");
      idle(1);

      // Repeat strobe from voter 0 is ignored
      step(1'b1, '0, '0);
      step(1'b0, 4'b0001, 4'b0001);
      step(1'b0, 4'b0001, 4'b0000);
      step(1'b0, 4'b0010, 4'b0000);
      step(1'b0, 4'b0100, 4'b0000);
      step(1'b0, 4'b1000, 4'b1000);
      finish_round("repeat_strobe");

      // Partial round: closes by timeout when enabled, otherwise stays busy
      step(1'b1, '0, '0);
      step(1'b0, 4'b0011, 4'b0011);
`ifdef VOTE_TIMEOUT_EN
      finish_round("timeout");
      idle(2);
      step(1'b1, '0, '0);
      step(1'b0, 4'b0001, 4'b0001);
      step(1'b0, 4'b0010, 4'b0010);
`endif
      idle(30);
      do_reset();

      // Fresh round after reset counts only new votes; start while busy ignored
      step(1'b1, '0, '0);
      step(1'b1, 4'b0100, 4'b0000);
      step(1'b1, 4'b1011, 4'b1000);
      finish_round("after_reset");

      // Randomized rounds; start issued in the done cycle opens the next round
      for (int r = 0; r < 30; r++) begin
         int c;
         step(1'b1, N'($urandom), N'($urandom));
         c = 0;
         while (m_phase != 0 && c < 80) begin
            step(1'($urandom), N'($urandom) & N'($urandom), N'($urandom));
            c++;
         end
         chk("rand_closed", 32'(m_phase), 32'd0);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end

      idle(4);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
